// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store. One transaction outstanding at a time, data has priority,
// hung accesses are aborted after TIMEOUT wait cycles.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DAT_WIDTH  = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DAT_WIDTH-1:0]  if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DAT_WIDTH-1:0]  d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DAT_WIDTH-1:0]  d_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DAT_WIDTH-1:0]  mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [DAT_WIDTH-1:0]  mem_rdata_i,
    output logic                  stall_o,
    output logic                  err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          idle;
    logic          expire;

    // Grants and stall are combinational; gated by reset so every output is 0 while held in reset
    always_comb begin
        idle     = (state == IDLE);
        expire   = (cnt == CW'(TIMEOUT - 1));
        d_gnt_o  = rst_n & idle & d_req_i;
        if_gnt_o = rst_n & idle & if_req_i & ~d_req_i;
        stall_o  = rst_n & (~idle | (if_req_i & d_req_i));
    end

    // Arbitration FSM with latched memory-side request and registered completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            d_rvalid_o  <= 1'b0;
            d_rdata_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;
            err_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_gnt_o) begin
                        state       <= BUSY_D;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        cnt         <= '0;
                    end else if (if_gnt_o) begin
                        state      <= BUSY_IF;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                        cnt        <= '0;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    // Ready and abort share one exit path; ready wins on the final wait cycle
                    if (mem_ready_i || expire) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        err_o     <= ~mem_ready_i;
                        if (state == BUSY_IF) begin
                            if_rvalid_o <= 1'b1;
                            if_rdata_o  <= mem_ready_i ? mem_rdata_i : '0;
                        end else begin
                            d_rvalid_o <= 1'b1;
                            d_rdata_o  <= (mem_ready_i && !mem_we_o) ? mem_rdata_i : '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed stimulus, completions checked by a
// scoreboard monitor, cycle-exact handshakes checked in the stimulus thread.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i, d_req_i, d_we_i, mem_ready_i;
    logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
    logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
    logic        mem_req_o, mem_we_o, stall_o, err_o;
    logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;

    typedef struct {
        bit          port;   // 0 = fetch, 1 = data
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"}, {31'b0, if_gnt_o}, 0);
        chk({tag, "_d_gnt"}, {31'b0, d_gnt_o}, 0);
        chk({tag, "_if_rvalid"}, {31'b0, if_rvalid_o}, 0);
        chk({tag, "_d_rvalid"}, {31'b0, d_rvalid_o}, 0);
        chk({tag, "_if_rdata"}, if_rdata_o, 0);
        chk({tag, "_d_rdata"}, d_rdata_o, 0);
        chk({tag, "_mem_req"}, {31'b0, mem_req_o}, 0);
        chk({tag, "_mem_we"}, {31'b0, mem_we_o}, 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
        chk({tag, "_stall"}, {31'b0, stall_o}, 0);
        chk({tag, "_err"}, {31'b0, err_o}, 0);
    endtask

    // Scoreboard monitor: every completion pulse pops and compares one expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (if_rvalid_o && d_rvalid_o) begin
                checks++;
                errors++;
                $display("FAIL mon_both_rvalid actual=1 required=0");
            end else if (if_rvalid_o || d_rvalid_o) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_rvalid actual=if:%0b/d:%0b required=none", if_rvalid_o, d_rvalid_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("mon_port", {31'b0, d_rvalid_o}, {31'b0, e.port});
                    chk("mon_rdata", d_rvalid_o ? d_rdata_o : if_rdata_o, e.rdata);
                    chk("mon_err", {31'b0, err_o}, {31'b0, e.err});
                end
            end else if (err_o) begin
                checks++;
                errors++;
                $display("FAIL mon_err_without_rvalid actual=1 required=0");
            end
        end
    end

    initial begin
        rst_n = 1'b0; if_req_i = 0; d_req_i = 0; d_we_i = 0; mem_ready_i = 0;
        if_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; mem_rdata_i = 0;
        smp();
        chk_all_zero("reset");
        cyc();
        rst_n = 1'b1;

        // Fetch only, zero wait states
        cyc(); if_req_i = 1; if_addr_i = 32'h40;
        smp();
        chk("f_if_gnt", {31'b0, if_gnt_o}, 1);
        chk("f_d_gnt", {31'b0, d_gnt_o}, 0);
        chk("f_stall_idle", {31'b0, stall_o}, 0);
        q.push_back('{port: 1'b0, rdata: 32'h0050_0093, err: 1'b0});
        cyc(); if_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h0050_0093;
        smp();
        chk("f_mem_req", {31'b0, mem_req_o}, 1);
        chk("f_mem_addr", mem_addr_o, 32'h40);
        chk("f_mem_we", {31'b0, mem_we_o}, 0);
        chk("f_stall_busy", {31'b0, stall_o}, 1);
        cyc(); mem_ready_i = 0;
        smp();
        chk("f_if_rvalid", {31'b0, if_rvalid_o}, 1);
        chk("f_mem_req_fall", {31'b0, mem_req_o}, 0);

        // Simultaneous requests: store wins, then fetch is granted
        cyc(); if_req_i = 1; if_addr_i = 32'h80;
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF;
        smp();
        chk("s_d_gnt", {31'b0, d_gnt_o}, 1);
        chk("s_if_gnt", {31'b0, if_gnt_o}, 0);
        chk("s_stall", {31'b0, stall_o}, 1);
        q.push_back('{port: 1'b1, rdata: 32'h0, err: 1'b0});
        cyc(); d_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
        smp();
        chk("s_mem_we", {31'b0, mem_we_o}, 1);
        chk("s_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk("s_mem_addr", mem_addr_o, 32'h100);
        chk("s_no_gnt_busy", {31'b0, if_gnt_o}, 0);
        cyc(); mem_ready_i = 0;
        smp();
        chk("s_d_rvalid", {31'b0, d_rvalid_o}, 1);
        chk("s_if_gnt_after", {31'b0, if_gnt_o}, 1);
        q.push_back('{port: 1'b0, rdata: 32'h0000_0013, err: 1'b0});

        // Fetch with 3 wait states
        for (int i = 0; i < 4; i++) begin
            cyc(); if_req_i = 0; mem_ready_i = (i == 3); mem_rdata_i = 32'h0000_0013;
            smp();
            chk("w_mem_req", {31'b0, mem_req_o}, 1);
            chk("w_mem_addr", mem_addr_o, 32'h80);
            chk("w_no_rvalid", {31'b0, if_rvalid_o}, 0);
        end
        cyc(); mem_ready_i = 0;
        smp();
        chk("w_if_rvalid", {31'b0, if_rvalid_o}, 1);
        chk("w_err", {31'b0, err_o}, 0);

        // Timeout: no ready at all
        cyc(); if_req_i = 1; if_addr_i = 32'hC0;
        smp();
        chk("t_if_gnt", {31'b0, if_gnt_o}, 1);
        q.push_back('{port: 1'b0, rdata: 32'h0, err: 1'b1});
        for (int i = 0; i < 15; i++) begin
            cyc(); if_req_i = 0;
            smp();
            chk("t_mem_req", {31'b0, mem_req_o}, 1);
            chk("t_no_err", {31'b0, err_o}, 0);
        end
        cyc();
        smp();
        chk("t_err", {31'b0, err_o}, 1);
        chk("t_if_rvalid", {31'b0, if_rvalid_o}, 1);
        chk("t_mem_req_fall", {31'b0, mem_req_o}, 0);
        chk("t_stall_idle", {31'b0, stall_o}, 0);

        // Ready on the final wait cycle wins over the abort
        cyc(); if_req_i = 1; if_addr_i = 32'hC4;
        smp();
        chk("t2_if_gnt", {31'b0, if_gnt_o}, 1);
        q.push_back('{port: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
        for (int i = 0; i < 15; i++) begin
            cyc(); if_req_i = 0; mem_ready_i = (i == 14); mem_rdata_i = 32'h1234_5678;
            smp();
            chk("t2_mem_req", {31'b0, mem_req_o}, 1);
        end
        cyc(); mem_ready_i = 0;
        smp();
        chk("t2_if_rvalid", {31'b0, if_rvalid_o}, 1);
        chk("t2_err", {31'b0, err_o}, 0);

        // Reset during a data load
        cyc(); d_req_i = 1; d_we_i = 0; d_addr_i = 32'h200;
        smp();
        chk("r_d_gnt", {31'b0, d_gnt_o}, 1);
        cyc(); d_req_i = 0;
        smp();
        chk("r_mem_req", {31'b0, mem_req_o}, 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        cyc(); mem_ready_i = 1; mem_rdata_i = 32'h5555_5555;
        smp();
        chk_all_zero("rst_hold");
        cyc(); mem_ready_i = 0; rst_n = 1'b1;
        cyc(); if_req_i = 1; if_addr_i = 32'h300;
        smp();
        chk("r_if_gnt", {31'b0, if_gnt_o}, 1);
        q.push_back('{port: 1'b0, rdata: 32'hAAAA_5555, err: 1'b0});
        cyc(); if_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'hAAAA_5555;
        cyc(); mem_ready_i = 0;
        smp();
        chk("r_if_rvalid", {31'b0, if_rvalid_o}, 1);

        // Spurious ready in IDLE
        cyc(); mem_ready_i = 1; mem_rdata_i = 32'h7777_7777;
        smp();
        chk("sp_stall", {31'b0, stall_o}, 0);
        chk("sp_mem_req", {31'b0, mem_req_o}, 0);
        cyc(); mem_ready_i = 0;
        smp();
        chk("sp_if_rvalid", {31'b0, if_rvalid_o}, 0);
        chk("sp_d_rvalid", {31'b0, d_rvalid_o}, 0);
        chk("sp_mem_req2", {31'b0, mem_req_o}, 0);

        // Data load returns memory data
        cyc(); d_req_i = 1; d_we_i = 0; d_addr_i = 32'h44;
        smp();
        chk("l_d_gnt", {31'b0, d_gnt_o}, 1);
        q.push_back('{port: 1'b1, rdata: 32'h0BAD_F00D, err: 1'b0});
        cyc(); d_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h0BAD_F00D;
        smp();
        chk("l_mem_addr", mem_addr_o, 32'h44);
        chk("l_mem_we", {31'b0, mem_we_o}, 0);
        cyc(); mem_ready_i = 0;
        smp();
        chk("l_d_rvalid", {31'b0, d_rvalid_o}, 1);

        // Drain: every expected completion must have been seen
        for (int i = 0; i < 20 && q.size() != 0; i++) smp();
        chk("drain_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
